uarc_send_scheduler: RTL and testbench

- Receiver-side scheduler for UARC `send` traffic into a core0-class core.
- Latches and masks per-bus send requests and picks one per grant using round-robin, not fixed priority.
- Offers the chosen bus, data and handler address to the core, then completes the bus handshake with a one-cycle ack.
- Holds the configuration registers (interrupt enables, WAIT selections, handler addresses) and tracks the in-service interrupt until return.

---
 rtl/uarc_pkg.sv | 8 +
 rtl/uarc_send_scheduler_if.sv | 37 +++
 rtl/rr_priority_encoder.sv | 28 ++
 rtl/uarc_send_scheduler.sv | 100 ++++++++++
 tb/tb_uarc_send_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uarc_pkg.sv
// Shared encodings for the UARC send scheduler: config targets and scheduler states.
package uarc_pkg;
  localparam logic [1:0] CFG_ENABLES    = 2'd0;
  localparam logic [1:0] CFG_SELECTIONS = 2'd1;
  localparam logic [1:0] CFG_ADDRESS    = 2'd2;

  typedef enum logic {IDLE, OFFER} state_t;
endpackage

// File: rtl/uarc_send_scheduler_if.sv
// Receiver-bus, config and core-offer signals of the send scheduler.
interface uarc_send_scheduler_if #(
  parameter int TOTAL_BUSES        = 4,
  parameter int WORD_WIDTH         = 32,
  parameter int PROGRAM_ADDR_WIDTH = 8,
  parameter int BUS_IDX_WIDTH      = 2
);
  logic [TOTAL_BUSES-1:0]                 receiver_sends;
  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_datas;
  logic [TOTAL_BUSES-1:0]                 receiver_send_acks;
  logic                                   cfg_we;
  logic [1:0]                             cfg_sel;
  logic [BUS_IDX_WIDTH-1:0]               cfg_bus;
  logic [WORD_WIDTH-1:0]                  cfg_value;
  logic                                   core_wait;
  logic                                   int_take;
  logic                                   int_return;
  logic                                   int_valid;
  logic [BUS_IDX_WIDTH-1:0]               int_bus;
  logic [WORD_WIDTH-1:0]                  int_data;
  logic [PROGRAM_ADDR_WIDTH-1:0]          int_address;
  logic                                   int_is_interrupt;
  logic                                   in_service;

  modport master (
    output receiver_sends, receiver_datas, cfg_we, cfg_sel, cfg_bus, cfg_value,
           core_wait, int_take, int_return,
    input  receiver_send_acks, int_valid, int_bus, int_data, int_address,
           int_is_interrupt, in_service
  );
  modport slave (
    input  receiver_sends, receiver_datas, cfg_we, cfg_sel, cfg_bus, cfg_value,
           core_wait, int_take, int_return,
    output receiver_send_acks, int_valid, int_bus, int_data, int_address,
           int_is_interrupt, in_service
  );
endinterface

// File: rtl/rr_priority_encoder.sv
// Round-robin priority encoder: first set line at or after start, wrapping.
module rr_priority_encoder #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] lines,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] index,
  output logic             on
);
  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0]   rot;
  logic [IDX_W-1:0]   k;
  logic [IDX_W:0]     sum;

  // Rotate so 'start' lands on bit 0, encode lowest bit, then rotate back.
  always_comb begin
    dbl = {lines, lines} >> start;
    rot = dbl[WIDTH-1:0];
    k   = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (rot[i]) k = IDX_W'(i);
    sum = {1'b0, k} + {1'b0, start};
    if (sum >= (IDX_W+1)'(WIDTH)) sum = sum - (IDX_W+1)'(WIDTH);
    index = sum[IDX_W-1:0];
    on    = |lines;
  end
endmodule

// File: rtl/uarc_send_scheduler.sv
// Round-robin scheduler of UARC send requests into a core0-class core,
// with the config registers and in-service interrupt tracking.
module uarc_send_scheduler
  import uarc_pkg::*;
#(
  parameter int WORD_MAG           = 5,
  parameter int TOTAL_BUSES        = 4,
  parameter int PROGRAM_ADDR_WIDTH = 8,
  parameter int BUS_IDX_WIDTH      = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1
) (
  input logic                  clk,
  input logic                  reset,
  uarc_send_scheduler_if.slave sif
);
  localparam int WORD_WIDTH = 1 << WORD_MAG;

  state_t                                         state_q, state_d;
  logic [TOTAL_BUSES-1:0]                         enable_mask, select_mask, mask, eligible;
  logic [TOTAL_BUSES-1:0][PROGRAM_ADDR_WIDTH-1:0] addr_tab;
  logic [BUS_IDX_WIDTH-1:0]                       ptr, pick, ptr_next;
  logic                                           pick_on, blocked, still_ok, load, grant;

  assign mask     = sif.core_wait ? select_mask : enable_mask;
  assign eligible = sif.receiver_sends & mask & ~sif.receiver_send_acks;
  assign blocked  = sif.in_service & ~sif.core_wait;
  assign still_ok = eligible[sif.int_bus];
  assign ptr_next = (sif.int_bus == BUS_IDX_WIDTH'(TOTAL_BUSES - 1)) ? '0
                  : sif.int_bus + BUS_IDX_WIDTH'(1);

  rr_priority_encoder #(.WIDTH(TOTAL_BUSES), .IDX_W(BUS_IDX_WIDTH)) u_rr (
    .lines(eligible), .start(ptr), .index(pick), .on(pick_on)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A take only counts while the offered bus is still eligible; otherwise withdraw.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    grant   = 1'b0;
    case (state_q)
      IDLE: if (pick_on && !blocked) begin
        load    = 1'b1;
        state_d = OFFER;
      end
      OFFER: begin
        if (!still_ok) state_d = IDLE;
        else if (sif.int_take) begin
          grant   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sif.receiver_send_acks <= '0;
      sif.int_valid          <= 1'b0;
      sif.int_bus            <= '0;
      sif.int_data           <= '0;
      sif.int_address        <= '0;
      sif.int_is_interrupt   <= 1'b0;
      sif.in_service         <= 1'b0;
      ptr                    <= '0;
      enable_mask            <= '0;
      select_mask            <= '0;
      addr_tab               <= '0;
    end else begin
      sif.receiver_send_acks <= grant ? (TOTAL_BUSES'(1) << sif.int_bus) : '0;
      sif.int_valid          <= (state_d == OFFER);
      if (load) begin
        sif.int_bus          <= pick;
        sif.int_data         <= sif.receiver_datas[pick];
        sif.int_address      <= addr_tab[pick];
        sif.int_is_interrupt <= ~sif.core_wait;
      end else if (state_q == OFFER) begin
        sif.int_data         <= sif.receiver_datas[sif.int_bus];
      end
      if (grant) ptr <= ptr_next;
      // A freshly taken interrupt outranks a coincident return.
      if (grant && sif.int_is_interrupt) sif.in_service <= 1'b1;
      else if (sif.int_return)           sif.in_service <= 1'b0;
      if (sif.cfg_we) begin
        case (sif.cfg_sel)
          CFG_ENABLES:    enable_mask <= sif.cfg_value[TOTAL_BUSES-1:0];
          CFG_SELECTIONS: select_mask <= sif.cfg_value[TOTAL_BUSES-1:0];
          CFG_ADDRESS:
            if (int'(sif.cfg_bus) < TOTAL_BUSES)
              addr_tab[sif.cfg_bus] <= sif.cfg_value[PROGRAM_ADDR_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uarc_send_scheduler.sv
// Scenario bench for uarc_send_scheduler with a queue of expected offers.
module tb_uarc_send_scheduler;
  import uarc_pkg::*;

  typedef struct {
    logic [1:0]  bus;
    logic [31:0] data;
    logic [7:0]  addr;
    logic        irq;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  uarc_send_scheduler_if #(.TOTAL_BUSES(4), .WORD_WIDTH(32), .PROGRAM_ADDR_WIDTH(8),
                           .BUS_IDX_WIDTH(2)) sif ();

  uarc_send_scheduler #(.WORD_MAG(5), .TOTAL_BUSES(4), .PROGRAM_ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .sif(sif)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [1:0] bus, input logic [31:0] val);
    sif.cfg_we = 1'b1; sif.cfg_sel = sel; sif.cfg_bus = bus; sif.cfg_value = val;
    step();
    sif.cfg_we = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (sif.int_valid !== 1'b1 && n < 20) begin step(); n++; end
    ok = (sif.int_valid === 1'b1);
  endtask

  task automatic pulse_take();
    sif.int_take = 1'b1;
    step();
    sif.int_take = 1'b0;
  endtask

  task automatic pulse_return();
    sif.int_return = 1'b1;
    step();
    sif.int_return = 1'b0;
  endtask

  task automatic push(input logic [1:0] b, input logic [31:0] d, input logic [7:0] a, input logic i);
    exp_t e;
    e.bus = b; e.data = d; e.addr = a; e.irq = i;
    q.push_back(e);
  endtask

  function automatic string got_s();
    return $sformatf("valid=%b bus=%0d data=%h addr=%h irq=%b", sif.int_valid, sif.int_bus,
                     sif.int_data, sif.int_address, sif.int_is_interrupt);
  endfunction

  function automatic string exp_s(input exp_t e);
    return $sformatf("valid=1 bus=%0d data=%h addr=%h irq=%b", e.bus, e.data, e.addr, e.irq);
  endfunction

  function automatic logic [31:0] bus_data(input int i);
    return 32'hA5A5_0000 | i;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_cmp++;
    if ({sif.receiver_send_acks, sif.int_valid, sif.int_bus, sif.int_data, sif.int_address,
         sif.int_is_interrupt, sif.in_service} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: acks=%b %s in_service=%b, required all zero",
               sif.receiver_send_acks, got_s(), sif.in_service);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_cfg_ignored();
    cfg_write(2'd3, 2'd0, 32'h0000_000F);
    cfg_write(CFG_ENABLES, 2'd0, 32'hFFFF_FFF0);
    sif.receiver_sends = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (sif.int_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL cfg_ignored: int_valid=%b cycle %0d, required 0", sif.int_valid, c);
      end
    end
    sif.receiver_sends = '0;
    step();
  endtask

  task automatic test_withdraw();
    exp_t e; bit ok;
    cfg_write(CFG_ENABLES, 2'd0, 32'h4);
    sif.receiver_sends = 4'b0100;
    push(2'd2, bus_data(2), 8'h00, 1'b1);
    wait_valid(ok);
    e = q.pop_front();
    n_cmp++;
    if (!ok || {sif.int_bus, sif.int_data, sif.int_address, sif.int_is_interrupt}
               !== {e.bus, e.data, e.addr, e.irq}) begin
      n_bad++; $display("FAIL withdraw_offer: %s, required %s", got_s(), exp_s(e));
    end
    sif.receiver_sends = 4'b0000;
    step();
    n_cmp++;
    if (sif.int_valid !== 1'b0 || sif.receiver_send_acks !== 4'b0000) begin
      n_bad++;
      $display("FAIL withdraw_drop: valid=%b acks=%b, required valid=0 acks=0000",
               sif.int_valid, sif.receiver_send_acks);
    end
    step();
    n_cmp++;
    if (sif.receiver_send_acks !== 4'b0000) begin
      n_bad++; $display("FAIL withdraw_noack: acks=%b, required 0000", sif.receiver_send_acks);
    end
    // Pointer still 0: bus 0 must win over bus 3.
    cfg_write(CFG_ENABLES, 2'd0, 32'hF);
    sif.receiver_sends = 4'b1001;
    push(2'd0, bus_data(0), 8'h00, 1'b1);
    wait_valid(ok);
    e = q.pop_front();
    n_cmp++;
    if (!ok || {sif.int_bus, sif.int_data, sif.int_address, sif.int_is_interrupt}
               !== {e.bus, e.data, e.addr, e.irq}) begin
      n_bad++; $display("FAIL withdraw_ptr: %s, required %s", got_s(), exp_s(e));
    end
    pulse_take();
    n_cmp++;
    if (sif.receiver_send_acks !== 4'b0001) begin
      n_bad++; $display("FAIL withdraw_ptr_ack: acks=%b, required 0001", sif.receiver_send_acks);
    end
    sif.receiver_sends = '0;
    step();
    pulse_return();
  endtask

  task automatic test_round_robin();
    exp_t e; bit ok;
    logic [1:0] order [3];
    order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd1;
    cfg_write(CFG_ADDRESS, 2'd1, 32'h11);
    cfg_write(CFG_ADDRESS, 2'd2, 32'h22);
    cfg_write(CFG_ENABLES, 2'd0, 32'h6);
    sif.receiver_sends = 4'b0110;
    for (int g = 0; g < 3; g++) begin
      push(order[g], bus_data(order[g]), (order[g] == 2'd1) ? 8'h11 : 8'h22, 1'b1);
      wait_valid(ok);
      e = q.pop_front();
      n_cmp++;
      if (!ok || {sif.int_bus, sif.int_data, sif.int_address, sif.int_is_interrupt}
                 !== {e.bus, e.data, e.addr, e.irq}) begin
        n_bad++; $display("FAIL rr_grant%0d: %s, required %s", g, got_s(), exp_s(e));
      end
      pulse_take();
      n_cmp++;
      if (sif.receiver_send_acks !== (4'b0001 << e.bus) || sif.int_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_ack%0d: acks=%b valid=%b, required acks=%b valid=0", g,
                 sif.receiver_send_acks, sif.int_valid, 4'b0001 << e.bus);
      end
      step();
      n_cmp++;
      if (sif.receiver_send_acks !== 4'b0000 || sif.in_service !== 1'b1) begin
        n_bad++;
        $display("FAIL rr_pulse%0d: acks=%b in_service=%b, required acks=0000 in_service=1",
                 g, sif.receiver_send_acks, sif.in_service);
      end
      if (g == 2) sif.receiver_sends = '0;
      pulse_return();
      n_cmp++;
      if (sif.in_service !== 1'b0) begin
        n_bad++; $display("FAIL rr_return%0d: in_service=%b, required 0", g, sif.in_service);
      end
    end
    step();
  endtask

  task automatic test_single();
    exp_t e;
    cfg_write(CFG_ADDRESS, 2'd0, 32'h3C);
    cfg_write(CFG_ENABLES, 2'd0, 32'h1);
    sif.receiver_datas[0] = 32'hDEADBEEF;
    sif.receiver_sends = 4'b0001;
    push(2'd0, 32'hDEADBEEF, 8'h3C, 1'b1);
    step();
    e = q.pop_front();
    n_cmp++;
    if (sif.int_valid !== 1'b1 ||
        {sif.int_bus, sif.int_data, sif.int_address, sif.int_is_interrupt}
        !== {e.bus, e.data, e.addr, e.irq}) begin
      n_bad++; $display("FAIL single_offer: %s, required %s", got_s(), exp_s(e));
    end
    pulse_take();
    n_cmp++;
    if (sif.receiver_send_acks !== 4'b0001) begin
      n_bad++; $display("FAIL single_ack: acks=%b, required 0001", sif.receiver_send_acks);
    end
    sif.receiver_sends = '0;
    sif.receiver_datas[0] = bus_data(0);
    step();
    pulse_return();
  endtask

  task automatic test_wait();
    exp_t e; bit ok;
    sif.core_wait = 1'b1;
    cfg_write(CFG_SELECTIONS, 2'd0, 32'h8);
    cfg_write(CFG_ENABLES, 2'd0, 32'h0);
    sif.receiver_sends = 4'b1000;
    push(2'd3, bus_data(3), 8'h00, 1'b0);
    wait_valid(ok);
    e = q.pop_front();
    n_cmp++;
    if (!ok || {sif.int_bus, sif.int_data, sif.int_address, sif.int_is_interrupt}
               !== {e.bus, e.data, e.addr, e.irq}) begin
      n_bad++; $display("FAIL wait_offer: %s, required %s", got_s(), exp_s(e));
    end
    pulse_take();
    n_cmp++;
    if (sif.receiver_send_acks !== 4'b1000) begin
      n_bad++; $display("FAIL wait_ack: acks=%b, required 1000", sif.receiver_send_acks);
    end
    step();
    n_cmp++;
    if (sif.in_service !== 1'b0) begin
      n_bad++; $display("FAIL wait_in_service: in_service=%b, required 0", sif.in_service);
    end
    sif.receiver_sends = '0;
    sif.core_wait = 1'b0;
    step();
  endtask

  task automatic test_in_service_block();
    exp_t e; bit ok;
    cfg_write(CFG_ENABLES, 2'd0, 32'h1);
    sif.receiver_sends = 4'b0001;
    push(2'd0, bus_data(0), 8'h3C, 1'b1);
    wait_valid(ok);
    e = q.pop_front();
    n_cmp++;
    if (!ok || {sif.int_bus, sif.int_data, sif.int_address, sif.int_is_interrupt}
               !== {e.bus, e.data, e.addr, e.irq}) begin
      n_bad++; $display("FAIL svc_first: %s, required %s", got_s(), exp_s(e));
    end
    pulse_take();
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++;
      if (sif.int_valid !== 1'b0 || sif.in_service !== 1'b1) begin
        n_bad++;
        $display("FAIL svc_block%0d: valid=%b in_service=%b, required valid=0 in_service=1",
                 c, sif.int_valid, sif.in_service);
      end
    end
    push(2'd0, bus_data(0), 8'h3C, 1'b1);
    pulse_return();
    n_cmp++;
    if (sif.int_valid !== 1'b0 || sif.in_service !== 1'b0) begin
      n_bad++;
      $display("FAIL svc_return: valid=%b in_service=%b, required valid=0 in_service=0",
               sif.int_valid, sif.in_service);
    end
    step();
    e = q.pop_front();
    n_cmp++;
    if (sif.int_valid !== 1'b1 ||
        {sif.int_bus, sif.int_data, sif.int_address, sif.int_is_interrupt}
        !== {e.bus, e.data, e.addr, e.irq}) begin
      n_bad++; $display("FAIL svc_reoffer: %s, required %s", got_s(), exp_s(e));
    end
    pulse_take();
    sif.receiver_sends = '0;
    step();
    pulse_return();
  endtask

  task automatic test_reset_during_offer();
    exp_t e; bit ok;
    cfg_write(CFG_ENABLES, 2'd0, 32'h2);
    sif.receiver_sends = 4'b0010;
    push(2'd1, bus_data(1), 8'h11, 1'b1);
    wait_valid(ok);
    e = q.pop_front();
    n_cmp++;
    if (!ok || {sif.int_bus, sif.int_data, sif.int_address, sif.int_is_interrupt}
               !== {e.bus, e.data, e.addr, e.irq}) begin
      n_bad++; $display("FAIL rst_offer: %s, required %s", got_s(), exp_s(e));
    end
    reset = 1'b1;
    sif.int_take = 1'b1;
    step();
    reset = 1'b0;
    sif.int_take = 1'b0;
    n_cmp++;
    if ({sif.receiver_send_acks, sif.int_valid, sif.int_bus, sif.int_data, sif.int_address,
         sif.int_is_interrupt, sif.in_service} !== '0) begin
      n_bad++;
      $display("FAIL rst_outputs: acks=%b %s in_service=%b, required all zero",
               sif.receiver_send_acks, got_s(), sif.in_service);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (sif.int_valid !== 1'b0 || sif.receiver_send_acks !== 4'b0000) begin
        n_bad++;
        $display("FAIL rst_masks%0d: valid=%b acks=%b, required valid=0 acks=0000",
                 c, sif.int_valid, sif.receiver_send_acks);
      end
    end
    sif.receiver_sends = '0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    sif.receiver_sends = '0;
    for (int i = 0; i < 4; i++) sif.receiver_datas[i] = bus_data(i);
    sif.cfg_we = 1'b0; sif.cfg_sel = '0; sif.cfg_bus = '0; sif.cfg_value = '0;
    sif.core_wait = 1'b0; sif.int_take = 1'b0; sif.int_return = 1'b0;
    test_reset();
    test_cfg_ignored();
    test_withdraw();
    test_round_robin();
    test_single();
    test_wait();
    test_in_service_block();
    test_reset_during_offer();
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
